inst_encode_loader: RTL and testbench

Encode-side counterpart of the core's instruction decode: accepts field-level instruction requests (format, funct3, registers, immediate), assembles legal RV32I/M 32-bit words, and streams them through a small FIFO into an instruction-memory write port at an auto-incrementing word address. It is used by boot/self-test sequencing and bench infrastructure to fill instruction memory. Requests that violate the ISA field rules are dropped and counted.

---
 rtl/inst_encode_loader_if.sv | 33 +++
 rtl/inst_encode_loader.sv | 171 +++++++++++++++++
 tb/tb_inst_encode_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encode_loader_if.sv
// Request/write-port bundle for inst_encode_loader: field-level instruction
// requests in, encoded words out to an instruction-memory write port.
interface inst_encode_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_fmt;
  logic [2:0]        req_funct3;
  logic              req_alt;
  logic              req_mext;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Request source and memory sink side.
  modport master (
    output req_valid, req_fmt, req_funct3, req_alt, req_mext,
           req_rd, req_rs1, req_rs2, req_imm, wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_fmt, req_funct3, req_alt, req_mext,
           req_rd, req_rs1, req_rs2, req_imm, wr_ready,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/inst_encode_loader.sv
// RV32I/M instruction encoder feeding an instruction-memory write port via a FIFO.
// Define INST_ENC_MEXT_EN to build M-extension (funct7 0000001) R-type encoding.
module inst_encode_loader #(
  parameter int              DEPTH     = 4,
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_clr,
  inst_encode_loader_if.slave bus,
  output logic                err_illegal,
  output logic [7:0]          err_cnt,
  output logic                busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  function automatic logic fits_s12(input logic signed [31:0] v);
    return (v >= -32'sd2048) && (v <= 32'sd2047);
  endfunction

  function automatic logic fits_s13(input logic signed [31:0] v);
    return (v >= -32'sd4096) && (v <= 32'sd4095);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [31:0] imm_s;
  logic [2:0]         f3;
  logic               legal_p0;
  logic [31:0]        word_p0_d, word_p0_q;
  logic               vld_p0_d, vld_p0_q;
  logic [31:0]        fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic               err_illegal_d, err_illegal_q;
  logic [7:0]         err_cnt_d, err_cnt_q;
  logic               full, empty, push, pop, accept, load;

  assign imm_s = bus.req_imm;
  assign f3    = bus.req_funct3;

  // Stage p0: field encode and ISA legality of the incoming request.
  always_comb begin
    legal_p0  = 1'b0;
    word_p0_d = '0;
    case (bus.req_fmt)
      3'd0: begin
        legal_p0  = !bus.req_alt || (f3 == 3'b000) || (f3 == 3'b101);
        word_p0_d = {(bus.req_alt ? 7'b0100000 : 7'b0000000), bus.req_rs2,
                     bus.req_rs1, f3, bus.req_rd, OP_R};
      end
      3'd1: begin
        if (f3 == 3'b001) begin
          legal_p0  = 1'b1;
          word_p0_d = {7'b0000000, bus.req_imm[4:0], bus.req_rs1, f3, bus.req_rd, OP_I};
        end else if (f3 == 3'b101) begin
          legal_p0  = 1'b1;
          word_p0_d = {(bus.req_alt ? 7'b0100000 : 7'b0000000), bus.req_imm[4:0],
                       bus.req_rs1, f3, bus.req_rd, OP_I};
        end else begin
          legal_p0  = fits_s12(imm_s);
          word_p0_d = {bus.req_imm[11:0], bus.req_rs1, f3, bus.req_rd, OP_I};
        end
      end
      3'd2: begin
        legal_p0  = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && fits_s12(imm_s);
        word_p0_d = {bus.req_imm[11:0], bus.req_rs1, f3, bus.req_rd, OP_L};
      end
      3'd3: begin
        legal_p0  = (f3 <= 3'd2) && fits_s12(imm_s);
        word_p0_d = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, f3,
                     bus.req_imm[4:0], OP_S};
      end
      3'd4: begin
        legal_p0  = (f3 != 3'd2) && (f3 != 3'd3) && !bus.req_imm[0] && fits_s13(imm_s);
        word_p0_d = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1, f3,
                     bus.req_imm[4:1], bus.req_imm[11], OP_B};
      end
      3'd5: begin
        legal_p0  = 1'b1;
        word_p0_d = {bus.req_imm[31:12], bus.req_rd, OP_LUI};
      end
      3'd6: begin
        legal_p0  = 1'b1;
        word_p0_d = {bus.req_imm[31:12], bus.req_rd, OP_AUIPC};
      end
      default: begin
        legal_p0  = 1'b0;
        word_p0_d = '0;
      end
    endcase
`ifdef INST_ENC_MEXT_EN
    if ((bus.req_fmt == 3'd0) && bus.req_mext) begin
      legal_p0              = !bus.req_alt;
      word_p0_d[31:25]      = 7'b0000001;
    end
`else
    if (bus.req_mext) legal_p0 = 1'b0;
`endif
  end

  // Stage p0 -> FIFO -> write port: handshake and pointer control.
  always_comb begin
    full          = (cnt_q == CNT_W'(DEPTH));
    empty         = (cnt_q == '0);
    pop           = !empty && bus.wr_ready;
    push          = vld_p0_q && (!full || pop);
    bus.req_ready = !vld_p0_q || push;
    accept        = bus.req_valid && bus.req_ready;
    load          = accept && legal_p0;
    vld_p0_d      = (vld_p0_q && !push) || load;
    wptr_d        = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d        = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d         = cnt_q + CNT_W'(push) - CNT_W'(pop);
    addr_d        = addr_q;
    if (start_clr)  addr_d = BASE_ADDR;
    else if (pop)   addr_d = addr_q + ADDR_W'(1);
    err_illegal_d = accept && !legal_p0;
    err_cnt_d     = err_cnt_q;
    if (start_clr)          err_cnt_d = '0;
    else if (err_illegal_d) err_cnt_d = sat_inc8(err_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q      <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      addr_q        <= BASE_ADDR;
      err_illegal_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      vld_p0_q      <= vld_p0_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      err_illegal_q <= err_illegal_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) word_p0_q <= word_p0_d;
    if (push) fifo_mem_q[wptr_q] <= word_p0_q;
  end

  // Write port: head of FIFO, zero data while idle.
  assign bus.wr_en   = !empty;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = empty ? 32'd0 : fifo_mem_q[rptr_q];
  assign err_illegal = err_illegal_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = vld_p0_q || !empty;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader: encodings, latency, backpressure,
// illegal handling, address wrap and asynchronous reset.
module tb_inst_encode_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_clr, err_illegal, busy;
  logic [7:0] err_cnt;
  logic       rst2_n, start_clr2, err_illegal2, busy2;
  logic [7:0] err_cnt2;

  inst_encode_loader_if #(.ADDR_W(10)) bus ();
  inst_encode_loader_if #(.ADDR_W(2))  bus2 ();

  inst_encode_loader #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(10'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start_clr(start_clr), .bus(bus.slave),
    .err_illegal(err_illegal), .err_cnt(err_cnt), .busy(busy));

  inst_encode_loader #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start_clr(start_clr2), .bus(bus2.slave),
    .err_illegal(err_illegal2), .err_cnt(err_cnt2), .busy(busy2));

  int errors = 0;
  int checks = 0;

  logic [41:0] wlog[$];
  logic [33:0] wlog2[$];
  always @(negedge clk) begin
    if (rst_n && bus.wr_en && bus.wr_ready) wlog.push_back({bus.wr_addr, bus.wr_data});
    if (rst2_n && bus2.wr_en && bus2.wr_ready) wlog2.push_back({bus2.wr_addr, bus2.wr_data});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [2:0] f3, input logic alt,
                         input logic mext, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    bus.req_fmt = fmt; bus.req_funct3 = f3; bus.req_alt = alt; bus.req_mext = mext;
    bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm;
  endtask

  task automatic wait_accept();
    int n = 0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_timeout req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%b required 0", busy); end
    tick(1);
  endtask

  task automatic pulse_clr();
    start_clr = 1'b1; tick(1); start_clr = 1'b0;
  endtask

  task automatic test_reset();
    checks += 7;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
    if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL rst_wr_addr got=%0d exp=0", bus.wr_addr); end
    if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data got=%h exp=0", bus.wr_data); end
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL rst_err_illegal got=%b exp=0", err_illegal); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_latency();
    set_req(3'd1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    wait_accept();
    checks += 3;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL lat_wr_en_n got=%b exp=0", bus.wr_en); end
    if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy got=%b exp=1", busy); end
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL lat_err got=%b exp=0", err_illegal); end
    tick(1);
    checks += 3;
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL lat_wr_en_n1 got=%b exp=1", bus.wr_en); end
    if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL lat_addr got=%0d exp=0", bus.wr_addr); end
    if (bus.wr_data !== 32'h00500093) begin errors++; $display("FAIL lat_addi got=%h exp=00500093", bus.wr_data); end
    tick(1);
    checks += 3;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL lat_wr_en_done got=%b exp=0", bus.wr_en); end
    if (bus.wr_addr !== 10'd1) begin errors++; $display("FAIL lat_addr_inc got=%0d exp=1", bus.wr_addr); end
    if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL lat_data_idle got=%h exp=0", bus.wr_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [6];
    exp_d = '{32'h402081B3, 32'h0020A423, 32'hFE208EE3, 32'h80000093, 32'h40315093, 32'h123452B7};
    pulse_clr();
    wlog.delete();
    set_req(3'd0, 3'b000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);          wait_accept();
    set_req(3'd3, 3'b010, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);          wait_accept();
    set_req(3'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);   wait_accept();
    set_req(3'd1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);   wait_accept();
    set_req(3'd1, 3'b101, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFE3);   wait_accept();
    set_req(3'd5, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);   wait_accept();
    wait_idle();
    checks++;
    if (wlog.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", wlog.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [41:0] got;
      got = (i < wlog.size()) ? wlog[i] : 42'bx;
      checks++;
      if (got !== {10'(i), exp_d[i]}) begin
        errors++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got, {10'(i), exp_d[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    pulse_clr();
    wlog.delete();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(3'd1, 3'b000, 1'b0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
      wait_accept();
    end
    set_req(3'd1, 3'b000, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd6);
    bus.req_valid = 1'b1;
    tick(3);
    checks += 5;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus.req_ready); end
    if (wlog.size() != 0) begin errors++; $display("FAIL bp_nowrite got=%0d exp=0", wlog.size()); end
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL bp_wr_en got=%b exp=1", bus.wr_en); end
    if (bus.wr_data !== 32'h00100093) begin errors++; $display("FAIL bp_head got=%h exp=00100093", bus.wr_data); end
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got=%b exp=1", busy); end
    bus.wr_ready = 1'b1;
    wait_accept();
    wait_idle();
    checks++;
    if (wlog.size() != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", wlog.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [41:0] got, exp;
      got = (i < wlog.size()) ? wlog[i] : 42'bx;
      exp = {10'(i), 32'((i + 1) << 20) | 32'((i + 1) << 7) | 32'h13};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_illegal();
    wlog.delete();
    set_req(3'd2, 3'b011, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0);
    wait_accept();
    checks += 2;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_load_pulse got=%b exp=1", err_illegal); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ill_not_loaded got=%b exp=0", busy); end
    set_req(3'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    wait_accept();
    checks++;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_branch_pulse got=%b exp=1", err_illegal); end
    set_req(3'd1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800);
    wait_accept();
    checks++;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_imm_pulse got=%b exp=1", err_illegal); end
    tick(1);
    checks += 5;
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL ill_pulse_end got=%b exp=0", err_illegal); end
    if (err_cnt !== 8'd3) begin errors++; $display("FAIL ill_cnt got=%0d exp=3", err_cnt); end
    if (wlog.size() != 0) begin errors++; $display("FAIL ill_nowrite got=%0d exp=0", wlog.size()); end
    if (bus.wr_addr !== 10'd6) begin errors++; $display("FAIL ill_addr_held got=%0d exp=6", bus.wr_addr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy got=%b exp=0", busy); end
    pulse_clr();
    checks += 2;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", err_cnt); end
    if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL clr_addr got=%0d exp=0", bus.wr_addr); end
    set_req(3'd7, 3'b000, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    wait_accept();
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL fmt7_cnt got=%0d exp=1", err_cnt); end
    start_clr = 1'b1;
    wait_accept();
    start_clr = 1'b0;
    checks += 2;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL clrill_pulse got=%b exp=1", err_illegal); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL clrill_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_mext();
    pulse_clr();
    wlog.delete();
    set_req(3'd0, 3'b000, 1'b1, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0);
    wait_accept();
    checks++;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL altmext_pulse got=%b exp=1", err_illegal); end
    set_req(3'd0, 3'b000, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0);
    wait_accept();
`ifdef INST_ENC_MEXT_EN
    checks++;
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL mul_pulse got=%b exp=0", err_illegal); end
    wait_idle();
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {10'd0, 32'h027302B3}) begin
      errors++; $display("FAIL mul_word n=%0d exp=1 word 000_027302B3", wlog.size());
    end
`else
    checks++;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL mul_pulse got=%b exp=1", err_illegal); end
    wait_idle();
    checks++;
    if (wlog.size() != 0) begin errors++; $display("FAIL mul_nowrite got=%0d exp=0", wlog.size()); end
`endif
  endtask

  task automatic test_wrap();
    bus2.wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.req_fmt = 3'd1; bus2.req_funct3 = 3'b000; bus2.req_rd = 5'(i + 1);
      bus2.req_imm = 32'(i + 1); bus2.req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready%0d got=%b exp=1", i, bus2.req_ready); end
      @(posedge clk); #1;
    end
    bus2.req_valid = 1'b0;
    tick(6);
    checks++;
    if (wlog2.size() != 5) begin errors++; $display("FAIL wrap_count got=%0d exp=5", wlog2.size()); end
    for (int i = 0; i < 5; i++) begin
      logic [33:0] got, exp;
      got = (i < wlog2.size()) ? wlog2[i] : 34'bx;
      exp = {2'(i), 32'((i + 1) << 20) | 32'((i + 1) << 7) | 32'h13};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL wrap_word%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    bus2.wr_ready = 1'b0;
    bus2.req_valid = 1'b1;
    tick(3);
    bus2.req_valid = 1'b0;
    tick(1);
    checks += 3;
    if (bus2.wr_en !== 1'b1) begin errors++; $display("FAIL ar_pre_wr_en got=%b exp=1", bus2.wr_en); end
    if (busy2 !== 1'b1) begin errors++; $display("FAIL ar_pre_busy got=%b exp=1", busy2); end
    if (bus2.wr_addr !== 2'd1) begin errors++; $display("FAIL ar_pre_addr got=%0d exp=1", bus2.wr_addr); end
    #2 rst2_n = 1'b0;
    #1;
    checks += 4;
    if (bus2.wr_en !== 1'b0) begin errors++; $display("FAIL ar_wr_en got=%b exp=0", bus2.wr_en); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", busy2); end
    if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got=%b exp=1", bus2.req_ready); end
    if (bus2.wr_addr !== 2'd0) begin errors++; $display("FAIL ar_addr got=%0d exp=0", bus2.wr_addr); end
    #1 rst2_n = 1'b1;
    tick(2);
    checks++;
    if (bus2.wr_en !== 1'b0) begin errors++; $display("FAIL ar_after got=%b exp=0", bus2.wr_en); end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; start_clr = 1'b0; start_clr2 = 1'b0;
    bus.req_valid = 1'b0; bus.wr_ready = 1'b1;
    set_req(3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus2.req_valid = 1'b0; bus2.wr_ready = 1'b1; bus2.req_fmt = 3'd0; bus2.req_funct3 = 3'd0;
    bus2.req_alt = 1'b0; bus2.req_mext = 1'b0; bus2.req_rd = 5'd0; bus2.req_rs1 = 5'd0;
    bus2.req_rs2 = 5'd0; bus2.req_imm = 32'd0;
    tick(2);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick(1);
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_mext();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
